// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the single-cycle MIPS core.
// Packs a byte stream big-endian into 32-bit words, writes them to the
// instruction memory at consecutive word addresses, then releases the core.
module imem_loader #(
  parameter int DEPTH = 256,  // instruction memory capacity in words
  parameter int CW    = 9     // word_count width, 2**CW > DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  input  logic          reload,
  output logic          wr_en,
  output logic [31:0]   wr_addr,
  output logic [31:0]   wr_data,
  output logic          cpu_run,
  output logic [CW-1:0] word_count,
  output logic          partial,
  output logic          overflow
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    WRITE = 2'd1,
    RUN   = 2'd2
  } state_e;

  // Index of the last word the memory can hold; reaching it without
  // in_last ends the load with overflow set.
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [31:0]   shift_q, shift_d;
  logic [CW-1:0] word_count_q, word_count_d;
  logic          partial_q, partial_d;
  logic          overflow_q, overflow_d;
  logic          last_q, last_d;     // current word was closed by in_last
  logic          accept;

  // in_ready is forced low while reset is held so no byte is taken then.
  assign in_ready = (state_q == LOAD) && !rst;
  assign accept   = in_valid && in_ready;

  // Write port is only driven during the single WRITE cycle; otherwise
  // it stays at zero so wr_addr never shows an out-of-range value.
  assign wr_en      = (state_q == WRITE);
  assign wr_addr    = wr_en ? 32'({word_count_q, 2'b00}) : 32'd0;
  assign wr_data    = wr_en ? shift_q : 32'd0;
  assign cpu_run    = (state_q == RUN);
  assign word_count = word_count_q;
  assign partial    = partial_q;
  assign overflow   = overflow_q;

  // State register and datapath registers, cleared asynchronously.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LOAD;
      byte_idx_q   <= 2'd0;
      shift_q      <= 32'd0;
      word_count_q <= '0;
      partial_q    <= 1'b0;
      overflow_q   <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      shift_q      <= shift_d;
      word_count_q <= word_count_d;
      partial_q    <= partial_d;
      overflow_q   <= overflow_d;
      last_q       <= last_d;
    end
  end

  // Next-state logic: byte packing in LOAD, word commit in WRITE,
  // reload handling in RUN.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can
    // leave one unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    shift_d      = shift_q;
    word_count_d = word_count_q;
    partial_d    = partial_q;
    overflow_d   = overflow_q;
    last_d       = last_q;

    unique case (state_q)
      LOAD: begin
        if (accept) begin
          // Big-endian: first byte of the word lands in the top lane.
          case (byte_idx_q)
            2'd0:    shift_d[31:24] = in_data;
            2'd1:    shift_d[23:16] = in_data;
            2'd2:    shift_d[15:8]  = in_data;
            default: shift_d[7:0]   = in_data;
          endcase
          byte_idx_d = byte_idx_q + 2'd1;
          if (in_last) begin
            last_d  = 1'b1;
            state_d = WRITE;
            // Lower lanes are already zero since the shift register is
            // cleared after every write.
            if (byte_idx_q != 2'd3) partial_d = 1'b1;
          end else if (byte_idx_q == 2'd3) begin
            state_d = WRITE;
          end
        end
      end

      WRITE: begin
        word_count_d = word_count_q + 1'b1;
        byte_idx_d   = 2'd0;
        shift_d      = 32'd0;
        last_d       = 1'b0;
        if (last_q) begin
          state_d = RUN;
        end else if (word_count_q == LAST_IDX) begin
          state_d    = RUN;
          overflow_d = 1'b1;
        end else begin
          state_d = LOAD;
        end
      end

      RUN: begin
        if (reload) begin
          state_d      = LOAD;
          byte_idx_d   = 2'd0;
          shift_d      = 32'd0;
          word_count_d = '0;
          partial_d    = 1'b0;
          overflow_d   = 1'b0;
          last_d       = 1'b0;
        end
      end

      default: state_d = LOAD;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader. Stimulus pushes the
// expected memory writes into a queue; a monitor pops and compares them.
module tb_imem_loader;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        reload = 1'b0;
  logic        sel = 1'b0;   // 0: DEPTH=256 instance, 1: DEPTH=4 instance

  logic        rdy0, we0, run0, part0, ovf0;
  logic [31:0] a0, d0;
  logic [8:0]  wc0;
  logic        rdy4, we4, run4, part4, ovf4;
  logic [31:0] a4, d4;
  logic [2:0]  wc4;

  logic        v0, v4;
  assign v0 = in_valid && !sel;
  assign v4 = in_valid && sel;

  imem_loader #(.DEPTH(256), .CW(9)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(v0), .in_last(in_last),
    .in_ready(rdy0), .reload(reload), .wr_en(we0), .wr_addr(a0), .wr_data(d0),
    .cpu_run(run0), .word_count(wc0), .partial(part0), .overflow(ovf0)
  );

  imem_loader #(.DEPTH(4), .CW(3)) dut4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(v4), .in_last(in_last),
    .in_ready(rdy4), .reload(reload), .wr_en(we4), .wr_addr(a4), .wr_data(d4),
    .cpu_run(run4), .word_count(wc4), .partial(part4), .overflow(ovf4)
  );

  // Views of whichever instance is currently selected.
  logic        rdy, run, part, ovf;
  logic [31:0] wc;
  assign rdy  = sel ? rdy4  : rdy0;
  assign run  = sel ? run4  : run0;
  assign part = sel ? part4 : part0;
  assign ovf  = sel ? ovf4  : ovf0;
  assign wc   = sel ? 32'(wc4) : 32'(wc0);

  always #5 clk = ~clk;

  int  n_checks = 0;
  int  n_pass   = 0;
  wr_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (!rst && (we0 || we4)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", we4 ? a4 : a0, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", we4 ? a4 : a0, e.addr);
        check("wr_data", we4 ? d4 : d0, e.data);
      end
      check("ready_low_in_write", 32'(we4 ? rdy4 : rdy0), 32'd0);
    end
  end

  task automatic expect_wr(input logic [31:0] addr, input logic [31:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_last  = 1'b0;
    reload   = 1'b0;
    rst      = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Present one byte after 'gap' idle cycles and wait for its handshake.
  task automatic send(input logic [7:0] b, input logic last, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_data  = b;
    in_last  = last;
    in_valid = 1'b1;
    n = 0;
    while (!rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("handshake_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // After the final handshake, cpu_run must rise two negedges later
  // (one WRITE cycle, then RUN).
  task automatic wait_run(input string name);
    int n;
    n = 0;
    while (!run && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n), 32'd2);
  endtask

  logic [7:0] prog1 [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h08, 8'h00, 8'h00, 8'h00};
  int         gaps  [12] = '{1, 0, 2, 0, 1, 1, 0, 3, 0, 1, 0, 2};

  initial begin
    // Reset values, observed while reset is held.
    #1;
    check("rst_in_ready", 32'(rdy0), 32'd0);
    check("rst_wr_en", 32'(we0), 32'd0);
    check("rst_wr_addr", a0, 32'd0);
    check("rst_wr_data", d0, 32'd0);
    check("rst_cpu_run", 32'(run0), 32'd0);
    check("rst_word_count", 32'(wc0), 32'd0);
    check("rst_partial", 32'(part0), 32'd0);
    check("rst_overflow", 32'(ovf0), 32'd0);
    do_reset();
    #1 check("load_in_ready", 32'(rdy0), 32'd1);

    // Back-to-back 8-byte program.
    expect_wr(32'h0, 32'h2008_0005);
    expect_wr(32'h4, 32'h0800_0000);
    for (int i = 0; i < 8; i++) send(prog1[i], i == 7, 0);
    wait_run("t1_run_latency");
    check("t1_word_count", wc, 32'd2);
    check("t1_partial", 32'(part), 32'd0);
    check("t1_overflow", 32'(ovf), 32'd0);

    // Stream ignored in RUN: hold valid, no write, status holds.
    in_data  = 8'hAA;
    in_valid = 1'b1;
    repeat (4) @(negedge clk);
    check("run_in_ready", 32'(rdy), 32'd0);
    check("run_word_count_hold", wc, 32'd2);
    in_valid = 1'b0;

    // Six bytes, last on byte 1 of word 1: zero-padded partial word.
    do_reset();
    expect_wr(32'h0, 32'h1112_1314);
    expect_wr(32'h4, 32'h1516_0000);
    for (int i = 0; i < 6; i++) send(8'(8'h11 + i), i == 5, 0);
    wait_run("t2_run_latency");
    check("t2_word_count", wc, 32'd2);
    check("t2_partial", 32'(part), 32'd1);
    check("t2_cpu_run", 32'(run), 32'd1);

    // Async reset after the 2nd byte of word 1 drops everything.
    do_reset();
    expect_wr(32'h0, 32'h0102_0304);
    for (int i = 0; i < 6; i++) send(8'(8'h01 + i), 1'b0, 0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(rdy0), 32'd0);
    check("mid_rst_word_count", 32'(wc0), 32'd0);
    check("mid_rst_wr_en", 32'(we0), 32'd0);
    check("mid_rst_cpu_run", 32'(run0), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    expect_wr(32'h0, 32'hCAFE_F00D);
    send(8'hCA, 1'b0, 0);
    send(8'hFE, 1'b0, 0);
    send(8'hF0, 1'b0, 0);
    send(8'h0D, 1'b1, 0);
    wait_run("t5_run_latency");
    check("t5_word_count", wc, 32'd1);

    // DEPTH=4 instance: 16 bytes without in_last overflow the memory.
    do_reset();
    sel = 1'b1;
    for (int w = 0; w < 4; w++)
      expect_wr(32'(w * 4), {8'(w*4+1), 8'(w*4+2), 8'(w*4+3), 8'(w*4+4)});
    for (int i = 0; i < 16; i++) send(8'(i + 1), 1'b0, 0);
    wait_run("ovf_run_latency");
    in_data  = 8'h55;
    in_valid = 1'b1;
    repeat (6) @(negedge clk);
    check("ovf_in_ready", 32'(rdy), 32'd0);
    in_valid = 1'b0;
    check("ovf_overflow", 32'(ovf), 32'd1);
    check("ovf_word_count", wc, 32'd4);
    check("ovf_partial", 32'(part), 32'd0);
    sel = 1'b0;

    // Gapped stream of 12 bytes: same packing as back-to-back.
    do_reset();
    expect_wr(32'h0, 32'hA0A1_A2A3);
    expect_wr(32'h4, 32'hA4A5_A6A7);
    expect_wr(32'h8, 32'hA8A9_AAAB);
    for (int i = 0; i < 12; i++) send(8'(8'hA0 + i), i == 11, gaps[i]);
    wait_run("gap_run_latency");
    check("gap_word_count", wc, 32'd3);
    check("gap_partial", 32'(part), 32'd0);

    // Reload from RUN, then a fresh one-word program.
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check("reload_cpu_run", 32'(run0), 32'd0);
    check("reload_word_count", 32'(wc0), 32'd0);
    check("reload_in_ready", 32'(rdy0), 32'd1);
    expect_wr(32'h0, 32'hDEAD_BEEF);
    send(8'hDE, 1'b0, 0);
    send(8'hAD, 1'b0, 0);
    send(8'hBE, 1'b0, 0);
    send(8'hEF, 1'b1, 0);
    wait_run("reload_run_latency");
    check("reload_final_count", wc, 32'd1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
